// File: rtl/dut_stim_sequencer.sv
// dut_stim_sequencer: deterministic stimulus/compare sequencer for differential simulation of
// a reference DUT against its synthesized netlist.
//
// Steps through NUM_VEC vectors of a synchronous vector ROM. For each vector it loads the
// ROM word into stim, holds it HOLD_CYC cycles, then samples both DUT output buses. A
// mismatch is recorded (sticky flag, first index and a saturating count). The reference output
// is folded into a 32-bit CRC-style signature.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - begin a run (accepted only when idle or done)
//   vec_addr        - vector ROM read address (equals the current vector index)
//   vec_data        - ROM read data for vec_addr
//   stim            - registered stimulus driven to both DUTs
//   y_a, y_b        - reference / synthesized DUT outputs
//   busy, done      - run in progress / run complete (done held until start or rst)
//   mismatch        - sticky y_a != y_b indication
//   mismatch_idx    - vector index of the first mismatch
//   mismatch_count  - saturating number of mismatching samples
//   signature       - running signature of y_a
module dut_stim_sequencer #(
  parameter int unsigned VEC_W            = 256,
  parameter int unsigned Y_W              = 550,
  parameter int unsigned NUM_VEC          = 22,
  parameter int unsigned ADDR_W           = 5,
  parameter int unsigned HOLD_CYC         = 1,
  parameter int unsigned CNT_W            = 8,
  parameter bit          STOP_ON_MISMATCH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  output logic [VEC_W-1:0]  stim,
  input  logic [Y_W-1:0]    y_a,
  input  logic [Y_W-1:0]    y_b,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mismatch_idx,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [31:0]       signature
);

  localparam int unsigned NChunk = (Y_W + 31) / 32;
  localparam int unsigned PadW   = NChunk * 32;
  localparam int unsigned HcW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_VEC - 1);
  localparam logic [HcW-1:0]    HoldLast = HcW'(HOLD_CYC - 1);
  localparam logic [31:0]       Poly     = 32'h04C11DB7;

  typedef enum logic [2:0] {StIdle, StLoad, StApply, StSample, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [HcW-1:0]      hold_q, hold_d;
  logic [VEC_W-1:0]    stim_q, stim_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mm_q, mm_d;
  logic [ADDR_W-1:0]   midx_q, midx_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;
  logic [31:0]         sig_q, sig_d;

  logic [PadW-1:0]     y_pad;
  logic [31:0]         fold;
  logic [31:0]         sig_next;
  logic                differ;

  // XOR-fold of y_a in 32-bit chunks; the top chunk is zero-padded.
  always_comb begin
    y_pad          = '0;
    y_pad[Y_W-1:0] = y_a;
    fold           = '0;
    for (int i = 0; i < int'(NChunk); i++) begin
      fold = fold ^ y_pad[i*32 +: 32];
    end
  end

  assign sig_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? Poly : 32'h0) ^ fold;
  assign differ   = (y_a != y_b);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mm_d    = mm_q;
    midx_d  = midx_q;
    mcnt_d  = mcnt_q;
    sig_d   = sig_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          idx_d   = '0;
          mm_d    = 1'b0;
          midx_d  = '0;
          mcnt_d  = '0;
          sig_d   = 32'hFFFF_FFFF;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        stim_d  = vec_data;
        hold_d  = '0;
        state_d = StApply;
      end
      StApply: begin
        if (hold_q == HoldLast) begin
          state_d = StSample;
        end else begin
          hold_d = hold_q + HcW'(1);
        end
      end
      StSample: begin
        if (differ) begin
          mm_d = 1'b1;
          if (!mm_q) midx_d = idx_q;
          if (!(&mcnt_q)) mcnt_d = mcnt_q + CNT_W'(1);
        end
        sig_d = sig_next;
        if ((idx_q == LastIdx) || (STOP_ON_MISMATCH && differ)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mm_q    <= 1'b0;
      midx_q  <= '0;
      mcnt_q  <= '0;
      sig_q   <= 32'hFFFF_FFFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mm_q    <= mm_d;
      midx_q  <= midx_d;
      mcnt_q  <= mcnt_d;
      sig_q   <= sig_d;
    end
  end

  // The ROM address register is the vector index itself.
  assign vec_addr       = idx_q;
  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch       = mm_q;
  assign mismatch_idx   = midx_q;
  assign mismatch_count = mcnt_q;
  assign signature      = sig_q;

endmodule

// File: tb/tb_dut_stim_sequencer.sv
// tb_dut_stim_sequencer: self-checking bench for dut_stim_sequencer.
// Four instances with different configurations share one vector ROM:
//   0: NUM_VEC=4 HOLD_CYC=2          1: NUM_VEC=1 HOLD_CYC=1
//   2: NUM_VEC=4 HOLD_CYC=1 stop=1   3: NUM_VEC=6 HOLD_CYC=1 CNT_W=2
// y_a is a fixed function of stim; y_b flips bit 0 of y_a on selected vectors.
module tb_dut_stim_sequencer;

  localparam int unsigned VW = 16;
  localparam int unsigned YW = 40;
  localparam int unsigned AW = 3;

  logic clk;
  logic [3:0] rst;
  logic [3:0] start;
  logic [AW-1:0] vaddr [4];
  logic [VW-1:0] vdata [4];
  logic [VW-1:0] stim  [4];
  logic [YW-1:0] ya    [4];
  logic [YW-1:0] yb    [4];
  logic          busy  [4];
  logic          done  [4];
  logic          mm    [4];
  logic [AW-1:0] midx  [4];
  logic [7:0]    mcnt  [4];
  logic [31:0]   sig   [4];

  logic [VW-1:0] rom [8];
  logic [VW-1:0] bad_stim [4];
  logic [7:0]    bad_idx  [4];
  logic          zero_y   [4];

  int n_pass = 0;
  int n_tot  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [YW-1:0] ya_of(input logic [VW-1:0] v, input logic zy);
    logic [31:0] m;
    m = {16'h0, v} * 32'h9E3779B1;
    return zy ? '0 : {v[7:0] ^ 8'h5A, m};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Cw = (g == 3) ? 2 : 8;
    logic [Cw-1:0] cnt_w;
    assign vdata[g] = rom[vaddr[g]];
    assign ya[g]    = ya_of(stim[g], zero_y[g]);
    assign yb[g]    = ya[g] ^ {{(YW-1){1'b0}}, (stim[g] == bad_stim[g]) | bad_idx[g][vaddr[g]]};
    assign mcnt[g]  = 8'(cnt_w);
    dut_stim_sequencer #(
      .VEC_W(VW), .Y_W(YW), .NUM_VEC((g == 1) ? 1 : (g == 3) ? 6 : 4), .ADDR_W(AW),
      .HOLD_CYC((g == 0) ? 2 : 1), .CNT_W(Cw), .STOP_ON_MISMATCH(g == 2)
    ) u_dut (
      .clk(clk), .rst(rst[g]), .start(start[g]), .vec_addr(vaddr[g]), .vec_data(vdata[g]),
      .stim(stim[g]), .y_a(ya[g]), .y_b(yb[g]), .busy(busy[g]), .done(done[g]),
      .mismatch(mm[g]), .mismatch_idx(midx[g]), .mismatch_count(cnt_w), .signature(sig[g])
    );
  end

  function automatic int nv_of(input int g);
    return (g == 1) ? 1 : (g == 3) ? 6 : 4;
  endfunction
  function automatic int h_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: walk the ROM applying the run rules directly.
  task automatic model(input int g, output logic e_mm, output int e_idx, output int e_cnt,
                       output logic [31:0] e_sig, output int e_np);
    logic [YW-1:0] a, b;
    logic [63:0]   pad;
    int            cmax;
    cmax  = (g == 3) ? 3 : 255;
    e_mm  = 1'b0; e_idx = 0; e_cnt = 0; e_sig = 32'hFFFF_FFFF; e_np = nv_of(g);
    for (int i = 0; i < nv_of(g); i++) begin
      a = ya_of(rom[i], zero_y[g]);
      b = a ^ YW'((rom[i] == bad_stim[g]) | bad_idx[g][i]);
      pad = 64'(a);
      e_sig = ({e_sig[30:0], 1'b0} ^ (e_sig[31] ? 32'h04C11DB7 : 32'h0)) ^
              pad[31:0] ^ pad[63:32];
      if (a != b) begin
        if (!e_mm) e_idx = i;
        e_mm = 1'b1;
        if (e_cnt < cmax) e_cnt++;
        if (g == 2) begin
          e_np = i + 1;
          break;
        end
      end
    end
  endtask

  // Start a run on instance g and follow it cycle by cycle until done (bounded).
  task automatic do_run(input int g, input int pulse_at, output int d_obs);
    logic        e_mm;
    logic [31:0] e_sig;
    int e_idx, e_cnt, e_np, h, i, p, busy_err, addr_err, stim_err;
    model(g, e_mm, e_idx, e_cnt, e_sig, e_np);
    h = h_of(g);
    busy_err = 0; addr_err = 0; stim_err = 0; d_obs = -1;
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    for (int s = 1; s <= 300; s++) begin
      if (s > 1) @(negedge clk);
      start[g] = (s == pulse_at);
      if (done[g]) begin
        d_obs = s - 1;
        break;
      end
      i = (s - 1) / (h + 2);
      p = (s - 1) % (h + 2);
      if (i > 7) i = 7;
      if (!busy[g]) busy_err++;
      if (int'(vaddr[g]) != i) addr_err++;
      if (p != 0 && stim[g] != rom[i]) stim_err++;
    end
    start[g] = 1'b0;
    chk("done_latency", 64'(d_obs), 64'(e_np * (h + 2)));
    chk("busy_during_run", 64'(busy_err), 64'd0);
    chk("vec_addr_seq", 64'(addr_err), 64'd0);
    chk("stim_seq", 64'(stim_err), 64'd0);
    chk("busy_after_done", 64'(busy[g]), 64'd0);
    chk("mismatch", 64'(mm[g]), 64'(e_mm));
    chk("mismatch_idx", 64'(midx[g]), 64'(e_idx));
    chk("mismatch_count", 64'(mcnt[g]), 64'(e_cnt));
    chk("signature", 64'(sig[g]), 64'(e_sig));
    chk("stim_final", 64'(stim[g]), 64'(rom[e_np - 1]));
  endtask

  typedef struct {
    int          g;
    logic        zy;
    logic [15:0] bs;
    logic [7:0]  bi;
    int          pulse;
    logic        e_mm;
    int          e_idx;
    int          e_cnt;
    int          e_d;
    logic        chk_sig;
    logic [31:0] e_sig;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int d;
    tbl[0] = '{0, 1'b0, 16'hFFFF, 8'h00, 0, 1'b0, 0, 0, 16, 1'b0, 32'h0};
    tbl[1] = '{0, 1'b0, 16'hFFFF, 8'h00, 0, 1'b0, 0, 0, 16, 1'b0, 32'h0};
    tbl[2] = '{0, 1'b0, 16'h0003, 8'h00, 5, 1'b1, 2, 1, 16, 1'b0, 32'h0};
    tbl[3] = '{1, 1'b1, 16'hFFFF, 8'h00, 0, 1'b0, 0, 0, 3,  1'b1, 32'hFB3EE249};
    tbl[4] = '{2, 1'b0, 16'h0002, 8'h00, 0, 1'b1, 1, 1, 6,  1'b0, 32'h0};
    tbl[5] = '{3, 1'b0, 16'hFFFF, 8'hFF, 0, 1'b1, 0, 3, 18, 1'b0, 32'h0};

    for (int k = 0; k < 8; k++) rom[k] = VW'(k + 1);
    for (int k = 0; k < 4; k++) begin
      bad_stim[k] = 16'hFFFF; bad_idx[k] = 8'h00; zero_y[k] = 1'b0;
    end
    rst = 4'hF; start = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_stim", 64'(stim[0]), 64'd0);
    chk("rst_vec_addr", 64'(vaddr[0]), 64'd0);
    chk("rst_busy_done", {62'd0, busy[0], done[0]}, 64'd0);
    chk("rst_mismatch", {mm[0], midx[0], mcnt[0]}, 64'd0);
    chk("rst_signature", 64'(sig[0]), 64'hFFFF_FFFF);
    rst = 4'h0;

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      zero_y[tbl[t].g]   = tbl[t].zy;
      bad_stim[tbl[t].g] = tbl[t].bs;
      bad_idx[tbl[t].g]  = tbl[t].bi;
      do_run(tbl[t].g, tbl[t].pulse, d);
      chk("tbl_done_edge", 64'(d), 64'(tbl[t].e_d));
      chk("tbl_mismatch", {mm[tbl[t].g], 63'(midx[tbl[t].g])},
          {tbl[t].e_mm, 63'(tbl[t].e_idx)});
      chk("tbl_count", 64'(mcnt[tbl[t].g]), 64'(tbl[t].e_cnt));
      if (tbl[t].chk_sig) chk("tbl_signature", 64'(sig[tbl[t].g]), 64'(tbl[t].e_sig));
    end

    // start held high re-runs one cycle after done.
    zero_y[1] = 1'b0;
    @(negedge clk); start[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_start_done1", 64'(done[1]), 64'd1);
    @(negedge clk);
    chk("hold_start_rerun", {62'd0, busy[1], done[1]}, 64'd2);
    repeat (3) @(negedge clk);
    chk("hold_start_done2", 64'(done[1]), 64'd1);
    start[1] = 1'b0;

    // Reset during APPLY of vector 2 (mismatch already recorded on vector 0).
    bad_stim[0] = 16'h0001; bad_idx[0] = 8'h00; zero_y[0] = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun_stim", 64'(stim[0]), 64'd3);
    chk("midrun_mismatch", 64'(mm[0]), 64'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_stim", 64'(stim[0]), 64'd0);
    chk("midrst_busy_done", {62'd0, busy[0], done[0]}, 64'd0);
    chk("midrst_mismatch", {mm[0], midx[0], mcnt[0]}, 64'd0);
    chk("midrst_signature", 64'(sig[0]), 64'hFFFF_FFFF);
    rst[0] = 1'b0;
    bad_stim[0] = 16'hFFFF;
    do_run(0, 0, d);

    // Randomized runs against the reference model.
    for (int it = 0; it < 12; it++) begin
      int g;
      g = (it % 3 == 0) ? 0 : (it % 3 == 1) ? 2 : 3;
      for (int k = 0; k < 8; k++) rom[k] = VW'($urandom_range(16'hFFFE, 0));
      bad_stim[g] = 16'hFFFF;
      bad_idx[g]  = 8'($urandom) & 8'($urandom);
      zero_y[g]   = ($urandom_range(3, 0) == 0);
      do_run(g, (g == 0) ? int'($urandom_range(6, 2)) : 0, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dut_stim_sequencer.md
Name: dut_stim_sequencer

Overview:
- Clocked stimulus/compare controller for differential fuzz simulation of a generated `top` design.
- Reads stimulus vectors from a synchronous vector ROM and drives the packed input bus {wire0..wire4} of two DUT instances (reference and synthesized netlist).
- Holds each vector a programmable number of cycles, then samples both `y` buses, flags any mismatch and folds the reference `y` into a 32-bit signature.
- Replaces free-running `#10` stimulus and `$strobe` dumping with a deterministic, synthesizable sequencer.

Parameters:
- VEC_W, 256: width of one stimulus vector / stim bus.
- Y_W, 550: width of each DUT output bus `y`.
- NUM_VEC, 22: number of vectors applied per run; must be >=1.
- ADDR_W, 5: vector ROM address width; 2^ADDR_W >= NUM_VEC.
- HOLD_CYC, 1: cycles each vector is held before sampling; must be >=1.
- CNT_W, 8: mismatch counter width.
- STOP_ON_MISMATCH, 0: 1 = end the run at the first mismatch.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a run; sampled in IDLE or DONE only.
- vec_addr, out, ADDR_W: vector ROM read address.
- vec_data, in, VEC_W: ROM read data, valid 1 cycle after vec_addr.
- stim, out, VEC_W: registered stimulus to both DUTs' {wire0,wire1,wire2,wire3,wire4}.
- y_a, in, Y_W: reference DUT output.
- y_b, in, Y_W: synthesized DUT output.
- busy, out, 1: run in progress.
- done, out, 1: run complete; held high until the next start or rst.
- mismatch, out, 1: sticky; set when y_a != y_b at any sample.
- mismatch_idx, out, ADDR_W: vector index of the first mismatch.
- mismatch_count, out, CNT_W: saturating count of mismatching samples.
- signature, out, 32: running signature of y_a.

Behaviour:
- Reset values (rst=1 at a posedge):
  - state=IDLE; stim=0; vec_addr=0; busy=0; done=0.
  - mismatch=0; mismatch_idx=0; mismatch_count=0; signature=32'hFFFFFFFF.
  - Reset mid-run aborts immediately to these values; no partial results are retained.
- States: IDLE, LOAD, APPLY, SAMPLE, DONE.
- IDLE / DONE:
  - On start=1, clear idx, mismatch, mismatch_idx and mismatch_count; set signature=FFFFFFFF, done=0, busy=1, vec_addr=0; go to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle):
  - vec_addr=idx.
  - Next edge: stim<=vec_data, hold counter<=0, go to APPLY.
- APPLY (HOLD_CYC cycles):
  - stim is stable.
  - When the counter reaches HOLD_CYC-1, go to SAMPLE.
- SAMPLE (1 cycle), at the closing edge:
  - If y_a != y_b, do all of the following:
    - set mismatch;
    - if this is the first mismatch, mismatch_idx<=idx;
    - mismatch_count<=count+1, saturating at all-ones.
  - Signature update:
    - fold = XOR of the 32-bit chunks of y_a, zero-padded to ceil(Y_W/32)*32.
    - signature <= ((sig<<1) ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ fold.
  - Next state:
    - if idx==NUM_VEC-1, or (STOP_ON_MISMATCH and a mismatch this sample), go to DONE with busy=0, done=1;
    - else idx++, vec_addr<=idx+1, go to LOAD.
- DONE: stim keeps the last vector; all results held stable.
- Latency:
  - Each vector takes HOLD_CYC+2 cycles.
  - done rises NUM_VEC*(HOLD_CYC+2) edges after the edge that sampled start.
  - busy is high for exactly those cycles.
- Boundary conditions:
  - NUM_VEC=1: a single LOAD/APPLY/SAMPLE pass.
  - mismatch_count does not wrap.
  - start held high continuously re-runs one cycle after each DONE.
  - idx never exceeds NUM_VEC-1; vec_addr stays in range.

Test Plan:
- Reset, run, restart: rst high for 2 cycles, then start, with NUM_VEC=4, HOLD_CYC=2 and y_a=y_b -> busy high for 16 cycles, done rises at edge 16 after start, mismatch=0, mismatch_count=0; a second start clears done and repeats identically.
- Vector ordering: ROM[i]=i+1, y_a=y_b=0, NUM_VEC=1 -> stim=1 for 2 cycles, signature=32'hFB3EE249, vec_addr sequence observed as 0 only.
- Mismatch capture: y_b=y_a^1 only while stim==3, NUM_VEC=4 -> mismatch=1, mismatch_idx=2, mismatch_count=1, run completes all 4 vectors.
- Early stop and saturation:
  - STOP_ON_MISMATCH=1, mismatch on idx 1 -> done after 2*(HOLD_CYC+2) cycles, mismatch_idx=1.
  - CNT_W=2 with every sample mismatching over 6 vectors -> mismatch_count=3.
- Reset mid-operation: assert rst during APPLY of vector 2 -> next cycle stim=0, busy=0, done=0, signature=FFFFFFFF; a start afterwards restarts from vec_addr=0.
- Ignored start: pulse start while busy -> no restart, idx sequence unchanged, done timing as in the reset/run scenario.
